// File: rtl/iterative_shifter_pkg.sv
// Shared definitions for the iterative shifter: shift mode codes and FSM state encoding.
package shifter_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/iterative_shifter_if.sv
// Request/response bundle between a datapath client and the iterative shifter.
interface iterative_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               start_i;
    logic [1:0]         mode_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;

    modport master (
        output start_i, mode_i, shamt_i, data_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, mode_i, shamt_i, data_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/iterative_shifter_shift_step.sv
// Combinational barrel stage: shifts a value by 0..STEP positions in one of four modes.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       mode,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] shifted
);

    // Select the shift flavour; for k==0 the rotate's right half shifts out completely.
    always_comb begin
        shifted = value;
        case (mode)
            MODE_SLL: shifted = value << k;
            MODE_SRL: shifted = value >> k;
            MODE_SRA: shifted = WIDTH'($signed(value) >>> k);
            MODE_ROL: shifted = (value << k) | (value >> (WIDTH - int'(k)));
            default:  shifted = value;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: accepts a request, shifts up to STEP bits per clock, pulses done.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    iterative_shifter_if.slave bus
);

    localparam int KW = $clog2(STEP + 1);

    state_t             state, state_n;
    logic [SHAMT_W-1:0] rem, rem_n;
    logic [1:0]         mode_q, mode_n;
    logic [WIDTH-1:0]   result_q, result_n;
    logic [WIDTH-1:0]   stepped;
    logic [KW-1:0]      k;
    logic               last_step;
    logic               busy_q;
    logic               done_q;

    // Positions to move this cycle: a full STEP, or whatever is left of the shift amount.
    always_comb begin
        if (int'(rem) >= STEP) begin
            k = KW'(STEP);
        end else begin
            k = KW'(rem);
        end
        last_step = (int'(rem) <= STEP);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .value   (result_q),
        .mode    (mode_q),
        .k       (k),
        .shifted (stepped)
    );

    // Next-state and datapath update; requests are only looked at outside SHIFT.
    always_comb begin
        state_n  = state;
        rem_n    = rem;
        mode_n   = mode_q;
        result_n = result_q;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    result_n = bus.data_i;
                    mode_n   = bus.mode_i;
                    rem_n    = bus.shamt_i;
                    state_n  = (bus.shamt_i != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_n = stepped;
                rem_n    = rem - SHAMT_W'(k);
                state_n  = last_step ? ST_DONE : ST_SHIFT;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, working registers and registered status flags; reset aborts any operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            rem      <= '0;
            mode_q   <= MODE_SLL;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            mode_q   <= mode_n;
            result_q <= result_n;
            busy_q   <= (state_n == ST_SHIFT);
            done_q   <= (state_n == ST_DONE);
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench: one STEP=1 and one STEP=4 shifter run the same directed requests.
module tb_iterative_shifter;
    import shifter_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          busy;
        int          done_cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [31:0] data;

    int   cyc;
    int   compared;
    int   mismatched;
    int   bc1;
    int   bc4;
    exp_t q1[$];
    exp_t q4[$];

    iterative_shifter_if #(.WIDTH(32)) if1 ();
    iterative_shifter_if #(.WIDTH(32)) if4 ();

    assign if1.start_i = start;
    assign if1.mode_i  = mode;
    assign if1.shamt_i = shamt;
    assign if1.data_i  = data;
    assign if4.start_i = start;
    assign if4.mode_i  = mode;
    assign if4.shamt_i = shamt;
    assign if4.data_i  = data;

    iterative_shifter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if4.slave)
    );

    // Free-running clock and edge counter used to time done pulses.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Single comparison point shared by stimulus and monitors.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Compare one completed operation against its scoreboard entry.
    task automatic score(input string tag, input exp_t e, input logic [31:0] res, input int bc);
        check_output({tag, "_result"}, res, e.res);
        check_output({tag, "_busy_cycles"}, bc, e.busy);
        check_output({tag, "_done_cycle"}, cyc, e.done_cyc);
    endtask

    // Monitor for the STEP=1 instance: counts busy cycles, pops an entry on each done.
    initial begin
        exp_t e;
        bc1 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc1 = 0;
            end else begin
                if (if1.busy_o) bc1++;
                if (if1.done_o) begin
                    if (q1.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL s1_unexpected_done: got done=1 at cycle %0d, required no completion", cyc);
                    end else begin
                        e = q1.pop_front();
                        score("s1", e, if1.result_o, bc1);
                    end
                    bc1 = 0;
                end
            end
        end
    end

    // Monitor for the STEP=4 instance.
    initial begin
        exp_t e;
        bc4 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc4 = 0;
            end else begin
                if (if4.busy_o) bc4++;
                if (if4.done_o) begin
                    if (q4.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL s4_unexpected_done: got done=1 at cycle %0d, required no completion", cyc);
                    end else begin
                        e = q4.pop_front();
                        score("s4", e, if4.result_o, bc4);
                    end
                    bc4 = 0;
                end
            end
        end
    end

    // Issue one request for a single cycle and record what both instances must produce.
    task automatic apply_stimulus(input logic [1:0] m, input logic [4:0] sh,
                                  input logic [31:0] d, input logic [31:0] exp_res);
        int e0;
        int n4;
        start = 1'b1;
        mode  = m;
        shamt = sh;
        data  = d;
        e0 = cyc + 1;
        n4 = (int'(sh) + 3) / 4;
        q1.push_back('{exp_res, int'(sh), e0 + int'(sh)});
        q4.push_back('{exp_res, n4, e0 + n4});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait, bounded, until every expected completion has been seen.
    task automatic wait_quiet();
        for (int i = 0; i < 200; i++) begin
            if (q1.size() == 0 && q4.size() == 0) break;
            @(negedge clk);
        end
        check_output("drain_pending", q1.size() + q4.size(), 0);
        q1.delete();
        q4.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = MODE_SLL;
        shamt = '0;
        data  = '0;

        #3;
        check_output("rst_busy_s1", if1.busy_o, 0);
        check_output("rst_done_s1", if1.done_o, 0);
        check_output("rst_result_s1", if1.result_o, 0);
        check_output("rst_busy_s4", if4.busy_o, 0);
        check_output("rst_done_s4", if4.done_o, 0);
        check_output("rst_result_s4", if4.result_o, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed shifts");
        apply_stimulus(MODE_SLL, 5'd2,  32'h0000_0001, 32'h0000_0004); wait_quiet();
        apply_stimulus(MODE_SRA, 5'd4,  32'h8000_0000, 32'hF800_0000); wait_quiet();
        apply_stimulus(MODE_SRL, 5'd4,  32'h8000_0000, 32'h0800_0000); wait_quiet();
        apply_stimulus(MODE_ROL, 5'd1,  32'h8000_0001, 32'h0000_0003); wait_quiet();
        apply_stimulus(MODE_SRL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF); wait_quiet();
        apply_stimulus(MODE_SLL, 5'd31, 32'h0000_0001, 32'h8000_0000); wait_quiet();
        apply_stimulus(MODE_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF); wait_quiet();
        apply_stimulus(MODE_ROL, 5'd8,  32'h1234_5678, 32'h3456_7812); wait_quiet();
        apply_stimulus(MODE_SRL, 5'd5,  32'hF000_0000, 32'h0780_0000); wait_quiet();
        apply_stimulus(MODE_SRA, 5'd6,  32'h4000_0000, 32'h0100_0000); wait_quiet();
        apply_stimulus(MODE_ROL, 5'd31, 32'h8000_0001, 32'hC000_0000); wait_quiet();
        apply_stimulus(MODE_SLL, 5'd30, 32'h0000_000F, 32'hC000_0000); wait_quiet();
        apply_stimulus(MODE_SRA, 5'd4,  32'h8765_4321, 32'hF876_5432); wait_quiet();

        $display("[TB] start pulsed while shifting");
        apply_stimulus(MODE_SLL, 5'd31, 32'h0000_0001, 32'h8000_0000);
        @(negedge clk);
        start = 1'b1;
        mode  = MODE_SRL;
        shamt = 5'd3;
        data  = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_quiet();

        $display("[TB] start held high through done");
        start = 1'b1;
        mode  = MODE_SLL;
        shamt = 5'd1;
        data  = 32'h0000_0001;
        e0 = cyc + 1;
        q1.push_back('{32'h0000_0002, 1, e0 + 1});
        q4.push_back('{32'h0000_0002, 1, e0 + 1});
        q1.push_back('{32'h1234_5678, 0, e0 + 2});
        q4.push_back('{32'h1234_5678, 0, e0 + 2});
        q1.push_back('{32'h0000_0007, 2, e0 + 5});
        q4.push_back('{32'h0000_0007, 1, e0 + 4});
        @(negedge clk);
        mode  = MODE_SRA;
        shamt = 5'd0;
        data  = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        mode  = MODE_ROL;
        shamt = 5'd2;
        data  = 32'hC000_0001;
        @(negedge clk);
        start = 1'b0;
        wait_quiet();

        $display("[TB] reset while shifting");
        apply_stimulus(MODE_SLL, 5'd20, 32'h0000_0001, 32'h0010_0000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("abort_busy_s1", if1.busy_o, 0);
        check_output("abort_done_s1", if1.done_o, 0);
        check_output("abort_result_s1", if1.result_o, 0);
        check_output("abort_busy_s4", if4.busy_o, 0);
        check_output("abort_done_s4", if4.done_o, 0);
        check_output("abort_result_s4", if4.result_o, 0);
        q1.delete();
        q4.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        check_output("post_abort_result_s1", if1.result_o, 0);
        check_output("post_abort_result_s4", if4.result_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
